// File: rtl/scan_sel_ctrl_pkg.sv
// Shared display constants: scan direction encodings, digit geometry and
// helpers for stepping the digit index around the frame.
package scan_sel_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DATA_W     = NUM_DIGITS * DIGIT_W;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } scan_dir_e;

    // Next digit index; the SEL_W-bit wrap gives mod-NUM_DIGITS stepping.
    function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] cur,
                                                  input scan_dir_e       dir);
        return (dir == DIR_DOWN) ? cur - SEL_W'(1) : cur + SEL_W'(1);
    endfunction

    // Index that opens a frame in the given direction.
    function automatic logic [SEL_W-1:0] frame_start(input scan_dir_e dir);
        return (dir == DIR_DOWN) ? SEL_W'(NUM_DIGITS - 1) : '0;
    endfunction

endpackage

// File: rtl/scan_sel_ctrl_tick_gen.sv
// Prescaler: counts enabled cycles 0..DIV-1 and flags the last one as a tick.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

    // Combinational so that en=0 or rst=1 suppresses the pulse in the same cycle.
    always_comb begin
        tick = en && !rst && (cnt == CNT_MAX);
    end

endmodule

// File: rtl/scan_sel_ctrl.sv
// Multiplexed display scanner: steps the digit select once per prescaled slot
// and presents the matching nibble of a per-frame snapshot of data_in.
module scan_sel_ctrl
    import scan_sel_ctrl_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [DATA_W-1:0] data_in,
    output logic [SEL_W-1:0]  sel,
    output logic [DIGIT_W-1:0] digit,
    output logic              tick,
    output logic              frame_done
);

    logic [DATA_W-1:0] shadow;
    logic [SEL_W-1:0]  sel_nxt;
    scan_dir_e         scan_dir;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // dir only matters on tick cycles, so a mid-slot change waits for the next advance.
    always_comb begin
        scan_dir   = scan_dir_e'(dir);
        sel_nxt    = step_sel(sel, scan_dir);
        frame_done = tick && (sel_nxt == frame_start(scan_dir));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel    <= '0;
            shadow <= '0;
        end else if (tick) begin
            sel <= sel_nxt;
            if (frame_done) begin
                shadow <= data_in;
            end
        end
    end

    assign digit = shadow[{sel, 2'b00} +: DIGIT_W];

endmodule

// File: tb/tb_scan_sel_ctrl.sv
// Randomised and directed bench for scan_sel_ctrl against a cycle-count based
// reference model; a second instance covers the DIV=1 corner.
module tb_scan_sel_ctrl;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, dir;
    logic [15:0] data_in;
    logic [1:0]  sel;
    logic [3:0]  digit;
    logic        tick, frame_done;

    logic        rst1, en1, dir1;
    logic [15:0] data1;
    logic [1:0]  sel1;
    logic [3:0]  digit1;
    logic        tick1, fd1;

    scan_sel_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .data_in(data_in),
        .sel(sel), .digit(digit), .tick(tick), .frame_done(frame_done)
    );

    scan_sel_ctrl #(.DIV(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .dir(dir1), .data_in(data1),
        .sel(sel1), .digit(digit1), .tick(tick1), .frame_done(fd1)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: enabled-cycle count since reset, digit position, snapshot digits.
    int         m_en_cycles = 0;
    int         m_sel = 0;
    logic [3:0] m_dig [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

    logic [7:0] dut_vec;
    assign dut_vec = {sel, digit, tick, frame_done};

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        return 4'((v >> (4 * k)) & 16'hF);
    endfunction

    function automatic logic m_tick();
        return en && !rst && ((m_en_cycles % DIV) == DIV - 1);
    endfunction

    function automatic int m_nsel();
        return dir ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
    endfunction

    function automatic logic m_fd();
        return m_tick() && (m_nsel() == (dir ? 3 : 0));
    endfunction

    function automatic logic [7:0] m_vec();
        return {2'(m_sel), m_dig[m_sel], m_tick(), m_fd()};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_en_cycles = 0;
            m_sel = 0;
            for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
        end else if (en) begin
            if (m_tick()) begin
                if (m_fd()) for (int k = 0; k < 4; k++) m_dig[k] = nib(data_in, k);
                m_sel = m_nsel();
            end
            m_en_cycles++;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; dir = 1'b0; data_in = 16'hFFFF;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if ({tick, frame_done} !== 2'b00)
                $display("FAIL reset_pulses cyc %0d: tick/fd got %b expected 00", c, {tick, frame_done});
            else passed++;
            step();
        end
        #1;
        total++;
        if ({sel, digit} !== 6'h00)
            $display("FAIL reset_state: sel/digit got %h expected 00", {sel, digit});
        else passed++;
        rst = 1'b0; en = 1'b0;
    endtask

    task automatic test_scan_up();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_dig [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        int first_tick = 0;
        int first_fd = 0;
        en = 1'b1; dir = 1'b0; data_in = 16'h4321;
        for (int c = 1; c <= 32; c++) begin
            #1;
            total++;
            if (dut_vec !== m_vec())
                $display("FAIL scan_up cyc %0d: sel/digit/tick/fd got %h expected %h", c, dut_vec, m_vec());
            else passed++;
            if (tick && first_tick == 0) first_tick = c;
            if (frame_done && first_fd == 0) first_fd = c;
            step();
            if (c % 4 == 0 && c <= 16) begin
                total++;
                if (sel !== exp_sel[c / 4 - 1])
                    $display("FAIL scan_up_sel cyc %0d: got %0d expected %0d", c, sel, exp_sel[c / 4 - 1]);
                else passed++;
            end
            if (c % 4 == 0 && c >= 16 && c <= 28) begin
                total++;
                if (digit !== exp_dig[(c - 16) / 4])
                    $display("FAIL scan_up_digit cyc %0d: got %h expected %h", c, digit, exp_dig[(c - 16) / 4]);
                else passed++;
            end
        end
        total++;
        if (first_tick !== 4 || first_fd !== 16)
            $display("FAIL scan_up_timing: first tick/fd got %0d/%0d expected 4/16", first_tick, first_fd);
        else passed++;
    endtask

    task automatic test_data_hold();
        logic [3:0] exp_new [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
        int budget = 0;
        logic done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            total++;
            if (dut_vec !== m_vec())
                $display("FAIL hold_pre cyc %0d: got %h expected %h", c, dut_vec, m_vec());
            else passed++;
            step();
        end
        data_in = 16'hABCD;
        while (!done && budget < 40) begin
            #1;
            total++;
            if (digit !== nib(16'h4321, int'(sel)) || dut_vec !== m_vec())
                $display("FAIL hold_old cyc %0d: got %h expected %h", budget, dut_vec, m_vec());
            else passed++;
            done = frame_done;
            step();
            budget++;
        end
        total++;
        if (!done) $display("FAIL hold_timeout: frame_done got 0 expected 1 within 40 cycles");
        else passed++;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (sel !== 2'(k) || digit !== exp_new[k])
                $display("FAIL hold_new slot %0d: sel/digit got %0d/%h expected %0d/%h", k, sel, digit, k, exp_new[k]);
            else passed++;
            repeat (4) step();
        end
    endtask

    task automatic test_dir_change();
        logic [1:0] exp_sel [3] = '{2'd1, 2'd0, 2'd3};
        logic       exp_fd  [3] = '{1'b0, 1'b0, 1'b1};
        repeat (10) begin
            #1;
            total++;
            if (dut_vec !== m_vec())
                $display("FAIL dir_pre: got %h expected %h", dut_vec, m_vec());
            else passed++;
            step();
        end
        dir = 1'b1;
        #1;
        total++;
        if (sel !== 2'd2) $display("FAIL dir_start: sel got %0d expected 2", sel);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            int   cnt = 0;
            logic seen = 1'b0;
            logic fdv = 1'b0;
            while (!seen && cnt < 2 * DIV) begin
                #1;
                total++;
                if (dut_vec !== m_vec())
                    $display("FAIL dir_cycle adv %0d: got %h expected %h", i, dut_vec, m_vec());
                else passed++;
                if (tick) begin
                    seen = 1'b1;
                    fdv = frame_done;
                end
                step();
                cnt++;
            end
            total++;
            if (!seen || sel !== exp_sel[i] || fdv !== exp_fd[i] || cnt != (i == 0 ? 2 : DIV))
                $display("FAIL dir_adv %0d: seen/sel/fd/cycles got %b/%0d/%b/%0d expected 1/%0d/%b/%0d",
                         i, seen, sel, fdv, cnt, exp_sel[i], exp_fd[i], (i == 0 ? 2 : DIV));
            else passed++;
        end
    endtask

    task automatic test_freeze();
        repeat (2) step();
        en = 1'b0;
        data_in = 16'h5A5A;
        for (int c = 0; c < 7; c++) begin
            #1;
            total++;
            if (tick !== 1'b0 || frame_done !== 1'b0 || sel !== 2'd3 || dut_vec !== m_vec())
                $display("FAIL freeze cyc %0d: got %h expected %h", c, dut_vec, m_vec());
            else passed++;
            step();
        end
        en = 1'b1;
        #1;
        total++;
        if (tick !== 1'b0) $display("FAIL resume_0: tick got %b expected 0", tick);
        else passed++;
        step();
        #1;
        total++;
        if (tick !== 1'b1 || dut_vec !== m_vec())
            $display("FAIL resume_1: got %h expected %h (tick 1)", dut_vec, m_vec());
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        logic seen = 1'b0;
        dir = 1'b0; en = 1'b1;
        repeat (7) begin
            #1;
            total++;
            if (dut_vec !== m_vec())
                $display("FAIL rstmid_pre: got %h expected %h", dut_vec, m_vec());
            else passed++;
            step();
        end
        #1;
        total++;
        if (sel !== 2'd3 || tick !== 1'b1)
            $display("FAIL rstmid_setup: sel/tick got %0d/%b expected 3/1", sel, tick);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({tick, frame_done} !== 2'b00)
            $display("FAIL rstmid_pulse: tick/fd got %b expected 00", {tick, frame_done});
        else passed++;
        step();
        rst = 1'b0;
        #1;
        total++;
        if ({sel, digit, tick, frame_done} !== 8'h00)
            $display("FAIL rstmid_after: sel/digit/tick/fd got %h expected 00", {sel, digit, tick, frame_done});
        else passed++;
        while (!seen && cnt < 2 * DIV) begin
            #1;
            cnt++;
            total++;
            if (dut_vec !== m_vec())
                $display("FAIL rstmid_cycle %0d: got %h expected %h", cnt, dut_vec, m_vec());
            else passed++;
            seen = tick;
            step();
        end
        total++;
        if (!seen || cnt != DIV)
            $display("FAIL rstmid_first_tick: cycle got %0d expected %0d", cnt, DIV);
        else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom % 50) == 0;
            en  = ($urandom % 5) != 0;
            if (($urandom % 7) == 0) dir = ~dir;
            if (($urandom % 10) == 0) data_in = 16'($urandom);
            #1;
            total++;
            if (dut_vec !== m_vec())
                $display("FAIL random cyc %0d: got %h expected %h", c, dut_vec, m_vec());
            else passed++;
            step();
        end
    endtask

    task automatic test_div1();
        rst = 1'b0; en = 1'b0;
        rst1 = 1'b1; en1 = 1'b1;
        #1;
        total++;
        if (tick1 !== 1'b0) $display("FAIL div1_reset: tick got %b expected 0", tick1);
        else passed++;
        step();
        rst1 = 1'b0; dir1 = 1'b0; data1 = 16'h8765;
        for (int i = 0; i < 12; i++) begin
            logic [3:0] ed;
            ed = (i >= 4) ? nib(16'h8765, i % 4) : 4'h0;
            #1;
            total++;
            if (tick1 !== 1'b1 || sel1 !== 2'(i % 4) || fd1 !== (i % 4 == 3) || digit1 !== ed)
                $display("FAIL div1 cyc %0d: tick/sel/fd/digit got %b/%0d/%b/%h expected 1/%0d/%b/%h",
                         i, tick1, sel1, fd1, digit1, i % 4, (i % 4 == 3), ed);
            else passed++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; data_in = '0;
        rst1 = 1'b1; en1 = 1'b0; dir1 = 1'b0; data1 = '0;
        test_reset();
        test_scan_up();
        test_data_hold();
        test_dir_change();
        test_freeze();
        test_reset_mid();
        test_random();
        test_div1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/scan_sel_ctrl.md
SCAN_SEL_CTRL -- requirements
Module: scan_sel_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 4, giving enabled clock cycles per digit slot (legal range 1..65535).
REQ-002 The block SHALL have port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port en  input  1  scan enable; 0 freezes all state.
REQ-005 The block SHALL have port dir  input  1  scan direction; 0 = up (0,1,2,3), 1 = down (3,2,1,0).
REQ-006 The block SHALL have port data_in  input  16  four 4-bit digit values; nibble k = data_in[4k+3:4k].
REQ-007 The block SHALL have port sel  output  2  current digit index, driving the a[1:0] input of the downstream 2-to-4 decoder.
REQ-008 The block SHALL have port digit  output  4  nibble of the frame shadow register selected by sel.
REQ-009 The block SHALL have port tick  output  1  one-cycle pulse marking a slot advance.
REQ-010 The block SHALL have port frame_done  output  1  one-cycle pulse marking the end of a full 4-slot frame.

Function
REQ-011 The prescaler SHALL count 0..DIV-1 on each cycle with en=1, wrap to 0 after DIV-1, and use a width of clog2(DIV), minimum 1 bit.
REQ-012 tick SHALL be 1 exactly on the enabled cycle where the prescaler equals DIV-1, and 0 otherwise; with DIV=1, tick SHALL be 1 on every enabled cycle.
REQ-013 On the clock edge ending a tick cycle, sel SHALL advance by one: +1 mod 4 if dir=0, -1 mod 4 if dir=1 (3->0 up, 0->3 down wrap).
REQ-014 dir SHALL be sampled only on tick cycles; a dir change mid-slot SHALL take effect at the next advance, with no skipped or repeated index.
REQ-015 The frame-start index SHALL be 0 for dir=0 and 3 for dir=1, evaluated with the dir value sampled on that tick.
REQ-016 On a tick whose advance moves sel to the frame-start index, the same edge SHALL load data_in into a 16-bit shadow register, and frame_done SHALL be 1 during that tick cycle.
REQ-017 data_in changes between loads SHALL NOT affect digit.
REQ-018 digit SHALL equal shadow[4*sel+3:4*sel] combinationally, with zero latency relative to sel.
REQ-019 When en=0, the prescaler, sel and shadow SHALL hold, and tick and frame_done SHALL be 0.
REQ-020 When en returns to 1, counting SHALL resume from the held prescaler value without restarting.

Reset
REQ-021 When rst=1 at a clock edge, the block SHALL set prescaler=0, sel=2'b00 and shadow=16'h0000, giving digit=4'h0.
REQ-022 tick and frame_done SHALL be 0 during any cycle with rst=1.
REQ-023 rst SHALL dominate en and dir, including mid-slot and mid-frame.
REQ-024 The first tick after reset deassertion SHALL occur DIV enabled cycles later.

Structure
REQ-025 The direction encodings (DIR_UP=0, DIR_DOWN=1) and the digit count (4) SHALL reside in the shared constants package/include used by the display blocks.
REQ-026 The prescaler SHALL be a separate sub-module tick_gen (ports clk, rst, en, tick; parameter DIV), instantiated once.
REQ-027 The sel/shadow/frame logic SHALL remain in scan_sel_ctrl.
REQ-028 sel SHALL connect directly to decoder24 .a in the display top level.

Verification
REQ-029 The bench SHALL check: DIV=4, rst for 2 cycles, then en=1, dir=0, data_in=16'h4321 -> sel steps 0,1,2,3,0 every 4 cycles; the first tick occurs on the 4th enabled cycle; frame_done pulses on the 3->0 tick; digit then reads 1,2,3,4.
REQ-030 The bench SHALL check: data_in changed to 16'hABCD mid-frame -> digit keeps the old values until the next frame_done, then reads D,C,B,A for sel 0..3.
REQ-031 The bench SHALL check: dir switched 0->1 while sel=2, mid-slot -> next advance goes 2->1, then 0, then 3 with frame_done on that tick; there is no double step.
REQ-032 The bench SHALL check: en=0 for 7 cycles at prescaler=2 -> sel, digit and prescaler are frozen and tick=0; after en=1, tick occurs exactly 1 cycle later.
REQ-033 The bench SHALL check: rst=1 asserted while sel=3 and prescaler=3 -> next edge gives sel=0, digit=0, tick=0 and frame_done=0; no tick occurs that cycle.
REQ-034 The bench SHALL check: DIV=1, en=1, dir=0 -> tick is constantly 1, sel cycles 0..3 every cycle, and frame_done is 1 every 4th cycle.
